// File: rtl/cla64_addsub_pipe.sv
// rtl/cla64_addsub_pipe.sv - 4-stage pipelined 64-bit CLA adder/subtractor with valid/ready handshake
module cla64_addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int GROUPS = 4,
  parameter int GW     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              c0,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  d,
  output logic [GROUPS-1:0] c,
  output logic              ovf
);

  // Nibbles per CLA group; GW is expected to be a multiple of 4.
  localparam int NB = GW / 4;

  // One GW-bit carry-lookahead group: nibble generate/propagate feed a
  // second lookahead level, then bit carries are formed inside each nibble.
  // Returns {carry_out, sum}.
  function automatic logic [GW:0] cla_group(
    input logic [GW-1:0] a,
    input logic [GW-1:0] b,
    input logic          cin
  );
    logic [GW-1:0] g;
    logic [GW-1:0] p;
    logic [GW:0]   cc;
    logic [NB-1:0] ng;
    logic [NB-1:0] np;
    logic [NB:0]   nc;
    g = a & b;
    p = a ^ b;
    for (int n = 0; n < NB; n++) begin
      ng[n] = g[4*n+3]
            | (p[4*n+3] & g[4*n+2])
            | (p[4*n+3] & p[4*n+2] & g[4*n+1])
            | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
      np[n] = &p[4*n +: 4];
    end
    nc[0] = cin;
    for (int n = 0; n < NB; n++) begin
      nc[n+1] = ng[n] | (np[n] & nc[n]);
    end
    cc = '0;
    for (int n = 0; n < NB; n++) begin
      cc[4*n] = nc[n];
      for (int j = 0; j < 3; j++) begin
        cc[4*n+j+1] = g[4*n+j] | (p[4*n+j] & cc[4*n+j]);
      end
    end
    cc[GW] = nc[NB];
    return {cc[GW], p ^ cc[GW-1:0]};
  endfunction

  logic w_en;
  logic r_out_valid;
  logic [WIDTH-1:0]  r_out_d;
  logic [GROUPS-1:0] r_out_c;
  logic              r_out_ovf;

  // The whole pipe advances together; it only stalls when a result is
  // waiting and downstream refuses it.
  assign w_en     = rst_n && (out_ready || !r_out_valid);
  assign in_ready = w_en;

  genvar k;
  generate
    for (k = 0; k < GROUPS - 1; k++) begin : g_st
      localparam int LO = k * GW;
      localparam int UI = WIDTH - LO;
      localparam int UO = WIDTH - LO - GW;

      logic          w_v_in;
      logic          w_sub_in;
      logic          w_cy_in;
      logic [UI-1:0] w_x_in;
      logic [UI-1:0] w_y_in;
      logic [GW:0]   w_grp;
      logic [LO+GW-1:0] w_d_next;
      logic [k:0]    w_c_next;

      logic             r_v;
      logic             r_sub;
      logic             r_cy;
      logic [UO-1:0]    r_xu;
      logic [UO-1:0]    r_yu;
      logic [LO+GW-1:0] r_d;
      logic [k:0]       r_c;

      assign w_grp = cla_group(w_x_in[GW-1:0], w_y_in[GW-1:0], w_cy_in);

      if (k == 0) begin : g_src
        // Subtraction becomes x + ~y + ~borrow at the pipe entrance.
        assign w_v_in   = in_valid;
        assign w_sub_in = sub;
        assign w_cy_in  = c0 ^ sub;
        assign w_x_in   = x;
        assign w_y_in   = sub ? ~y : y;
        assign w_d_next = w_grp[GW-1:0];
        assign w_c_next = w_grp[GW] ^ w_sub_in;
      end else begin : g_src
        assign w_v_in   = g_st[k-1].r_v;
        assign w_sub_in = g_st[k-1].r_sub;
        assign w_cy_in  = g_st[k-1].r_cy;
        assign w_x_in   = g_st[k-1].r_xu;
        assign w_y_in   = g_st[k-1].r_yu;
        assign w_d_next = {w_grp[GW-1:0], g_st[k-1].r_d};
        assign w_c_next = {w_grp[GW] ^ w_sub_in, g_st[k-1].r_c};
      end

      // Stage k: resolve group k, forward the carry and the unused upper operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v   <= 1'b0;
          r_sub <= 1'b0;
          r_cy  <= 1'b0;
          r_xu  <= '0;
          r_yu  <= '0;
          r_d   <= '0;
          r_c   <= '0;
        end else if (w_en) begin
          r_v   <= w_v_in;
          r_sub <= w_sub_in;
          r_cy  <= w_grp[GW];
          r_xu  <= w_x_in[UI-1:GW];
          r_yu  <= w_y_in[UI-1:GW];
          r_d   <= w_d_next;
          r_c   <= w_c_next;
        end
      end
    end
  endgenerate

  logic [GW:0] w_last;
  logic        w_msb_cin;

  assign w_last = cla_group(g_st[GROUPS-2].r_xu, g_st[GROUPS-2].r_yu, g_st[GROUPS-2].r_cy);
  // Carry into the MSB recovered from its sum bit and operand bits.
  assign w_msb_cin = w_last[GW-1] ^ g_st[GROUPS-2].r_xu[GW-1] ^ g_st[GROUPS-2].r_yu[GW-1];

  // Output stage: top group, flags and overflow; data only updates on a real result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_d     <= '0;
      r_out_c     <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= g_st[GROUPS-2].r_v;
      if (g_st[GROUPS-2].r_v) begin
        r_out_d   <= {w_last[GW-1:0], g_st[GROUPS-2].r_d};
        r_out_c   <= {w_last[GW] ^ g_st[GROUPS-2].r_sub, g_st[GROUPS-2].r_c};
        r_out_ovf <= w_last[GW] ^ w_msb_cin;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign d         = r_out_d;
  assign c         = r_out_c;
  assign ovf       = r_out_ovf;

endmodule

// File: tb/tb_cla64_addsub_pipe.sv
// tb/tb_cla64_addsub_pipe.sv - self-checking bench for cla64_addsub_pipe
module tb_cla64_addsub_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  c;
    logic        ovf;
  } res_t;

  localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINS = 66'sh3_8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic [63:0] y;
  logic        c0;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d;
  logic [3:0]  c;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla64_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c0(c0), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .c(c), .ovf(ovf)
  );

  // Reference: plain wide arithmetic on the operands.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic s);
    res_t r;
    logic [64:0] la, lb, lci, mask;
    logic signed [65:0] sa, sb, sc, sr;
    lci = {64'b0, ci};
    for (int k = 0; k < 4; k++) begin
      mask = (65'd1 << (16 * (k + 1))) - 65'd1;
      la = {1'b0, a} & mask;
      lb = {1'b0, b} & mask;
      if (s) r.c[k] = (la < lb + lci);
      else   r.c[k] = ((la + lb + lci) >> (16 * (k + 1))) != 65'd0;
    end
    r.d = s ? (a - b - {63'b0, ci}) : (a + b + {63'b0, ci});
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    sc = {65'b0, ci};
    sr = s ? (sa - sb - sc) : (sa + sb + sc);
    r.ovf = (sr > MAXS) || (sr < MINS);
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [63:0] xx, input logic [63:0] yy,
                       input logic cc, input logic ss, input logic ordy);
    @(negedge clk);
    in_valid = iv; x = xx; y = yy; c0 = cc; sub = ss; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; c0 = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_d got=%h exp=0", d); end
    checks++; if (c !== 4'd0) begin failures++; $display("FAIL reset_c got=%b exp=0000", c); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [63:0] vx [6];
    logic [63:0] vy [6];
    logic        vc [6];
    logic        vs [6];
    logic [63:0] ed [6];
    logic [3:0]  ec [6];
    logic        eo [6];
    int nout;
    vx[0] = 64'hFFFF_FFFF_FFFF_FFFE; vy[0] = 64'd1; vc[0] = 0; vs[0] = 0; ed[0] = 64'hFFFF_FFFF_FFFF_FFFF; ec[0] = 4'b0000; eo[0] = 0;
    vx[1] = 64'hFFFF_FFFF_FFFF_FFFF; vy[1] = 64'd0; vc[1] = 1; vs[1] = 0; ed[1] = 64'h0;                   ec[1] = 4'b1111; eo[1] = 0;
    vx[2] = 64'h7FFF_FFFF_FFFF_FFFF; vy[2] = 64'd1; vc[2] = 0; vs[2] = 0; ed[2] = 64'h8000_0000_0000_0000; ec[2] = 4'b0111; eo[2] = 1;
    vx[3] = 64'h0;                   vy[3] = 64'd1; vc[3] = 0; vs[3] = 1; ed[3] = 64'hFFFF_FFFF_FFFF_FFFF; ec[3] = 4'b1111; eo[3] = 0;
    vx[4] = 64'h8000_0000_0000_0000; vy[4] = 64'd1; vc[4] = 0; vs[4] = 1; ed[4] = 64'h7FFF_FFFF_FFFF_FFFF; ec[4] = 4'b0111; eo[4] = 1;
    vx[5] = 64'd5;                   vy[5] = 64'd3; vc[5] = 1; vs[5] = 1; ed[5] = 64'd1;                  ec[5] = 4'b0000; eo[5] = 0;
    nout = 0;
    for (int it = 0; it < 14; it++) begin
      if (it < 6) drive(1'b1, vx[it], vy[it], vc[it], vs[it], 1'b1);
      else        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      if (it < 6) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir_in_ready it=%0d got=%b exp=1", it, in_ready); end
      end
      checks++;
      if (out_valid !== (it >= 4 && it < 10)) begin
        failures++; $display("FAIL dir_latency it=%0d out_valid=%b exp=%b", it, out_valid, (it >= 4 && it < 10));
      end
      if (out_valid === 1'b1 && nout < 6) begin
        checks++;
        if (d !== ed[nout] || c !== ec[nout] || ovf !== eo[nout]) begin
          failures++;
          $display("FAIL dir_result%0d got d=%h c=%b ovf=%b exp d=%h c=%b ovf=%b", nout, d, c, ovf, ed[nout], ec[nout], eo[nout]);
        end
        nout++;
      end
    end
    checks++; if (nout != 6) begin failures++; $display("FAIL dir_count got=%0d exp=6", nout); end
  endtask

  task automatic test_back_pressure;
    logic [63:0] got [$];
    logic [63:0] hold_d;
    logic [3:0]  hold_c;
    logic        hold_o;
    int issued, stall_left;
    logic first_seen, stalling;
    issued = 0; stall_left = 3; first_seen = 0;
    for (int it = 0; it < 40 && got.size() < 6; it++) begin
      @(negedge clk);
      c0 = 1'b0; sub = 1'b0;
      if (issued < 6) begin in_valid = 1'b1; x = 64'(issued + 1); y = 64'(issued + 1); end
      else begin in_valid = 1'b0; x = '0; y = '0; end
      #1;
      if (out_valid === 1'b1) first_seen = 1'b1;
      stalling = first_seen && (stall_left > 0);
      out_ready = !stalling;
      #1;
      if (stalling) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_stall got=%b exp=0", in_ready); end
        if (stall_left < 3) begin
          checks++;
          if (out_valid !== 1'b1 || d !== hold_d || c !== hold_c || ovf !== hold_o) begin
            failures++; $display("FAIL bp_stable got v=%b d=%h c=%b o=%b exp v=1 d=%h c=%b o=%b", out_valid, d, c, ovf, hold_d, hold_c, hold_o);
          end
        end
        hold_d = d; hold_c = c; hold_o = ovf;
        stall_left--;
      end
      if (in_valid && in_ready) issued++;
      if (out_valid && out_ready) got.push_back(d);
    end
    checks++; if (got.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== 64'(2 * (i + 1))) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got[i], 2 * (i + 1)); end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_bubbles;
    res_t exp_q [$];
    res_t e;
    logic [63:0] xx, yy;
    logic cc, ss;
    for (int it = 0; it < 10; it++) begin
      xx = {$urandom(), $urandom()}; yy = {$urandom(), $urandom()};
      cc = 1'($urandom_range(1)); ss = 1'($urandom_range(1));
      if (it < 4 && (it % 2 == 0)) begin
        drive(1'b1, xx, yy, cc, ss, 1'b1);
        if (in_ready) exp_q.push_back(model(xx, yy, cc, ss));
      end else begin
        drive(1'b0, xx, yy, cc, ss, 1'b1);
      end
      checks++;
      if (out_valid !== (it == 4 || it == 6)) begin
        failures++; $display("FAIL bub_pattern it=%0d out_valid=%b exp=%b", it, out_valid, (it == 4 || it == 6));
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (d !== e.d || c !== e.c || ovf !== e.ovf) begin
          failures++; $display("FAIL bub_result got d=%h c=%b o=%b exp d=%h c=%b o=%b", d, c, ovf, e.d, e.c, e.ovf);
        end
      end
    end
  endtask

  task automatic test_random;
    res_t exp_q [$];
    res_t e;
    logic [63:0] xx, yy, pd;
    logic [3:0] pc;
    logic po, prev_stall, iv, ordy, cc, ss;
    int sel;
    prev_stall = 1'b0; pd = '0; pc = '0; po = 1'b0;
    for (int it = 0; it < 420; it++) begin
      sel = $urandom_range(3);
      xx = {$urandom(), $urandom()};
      yy = {$urandom(), $urandom()};
      if (sel == 1) yy = ~xx;
      if (sel == 2) xx = '1;
      if (sel == 3) yy = xx;
      cc = 1'($urandom_range(1)); ss = 1'($urandom_range(1));
      iv = (it < 400) && ($urandom_range(3) != 0);
      ordy = (it >= 400) || ($urandom_range(3) != 0);
      drive(iv, xx, yy, cc, ss, ordy);
      checks++;
      if (in_ready !== (out_ready || !out_valid)) begin
        failures++; $display("FAIL rnd_in_ready it=%0d got=%b exp=%b", it, in_ready, (out_ready || !out_valid));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || d !== pd || c !== pc || ovf !== po) begin
          failures++; $display("FAIL rnd_hold it=%0d got v=%b d=%h exp v=1 d=%h", it, out_valid, d, pd);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra it=%0d got d=%h exp none", it, d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || c !== e.c || ovf !== e.ovf) begin
            failures++; $display("FAIL rnd_result it=%0d got d=%h c=%b o=%b exp d=%h c=%b o=%b", it, d, c, ovf, e.d, e.c, e.ovf);
          end
        end
      end
      if (iv && in_ready) exp_q.push_back(model(xx, yy, cc, ss));
      prev_stall = out_valid && !out_ready;
      pd = d; pc = c; po = ovf;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_in_flight;
    res_t e0, e1;
    logic [63:0] xa, ya, xb, yb;
    xa = {$urandom(), $urandom()}; ya = {$urandom(), $urandom()};
    xb = {$urandom(), $urandom()}; yb = {$urandom(), $urandom()};
    e0 = model(xa, ya, 1'b0, 1'b0);
    drive(1'b1, xa, ya, 1'b0, 1'b0, 1'b1);
    drive(1'b1, xb, yb, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || d !== e0.d) begin
      failures++; $display("FAIL rif_pre got v=%b d=%h exp v=1 d=%h", out_valid, d, e0.d);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || d !== 64'd0 || c !== 4'd0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rif_async got v=%b d=%h c=%b o=%b rdy=%b exp all 0", out_valid, d, c, ovf, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int it = 0; it < 6; it++) begin
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_flushed it=%0d got=%b exp=0", it, out_valid); end
    end
    e1 = model(xb, yb, 1'b1, 1'b1);
    for (int it = 0; it < 6; it++) begin
      drive(it == 0, xb, yb, 1'b1, 1'b1, 1'b1);
      checks++;
      if (out_valid !== (it == 4)) begin failures++; $display("FAIL rif_latency it=%0d got=%b exp=%b", it, out_valid, (it == 4)); end
      if (it == 4) begin
        checks++;
        if (d !== e1.d || c !== e1.c || ovf !== e1.ovf) begin
          failures++; $display("FAIL rif_result got d=%h c=%b o=%b exp d=%h c=%b o=%b", d, c, ovf, e1.d, e1.c, e1.ovf);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_bubbles();
    test_random();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
